// File: rtl/glitch_pulse_seq.sv
// glitch_pulse_seq: multi-pulse glitch sequencer with per-pulse programmable delay and width
// Ports: cfg_we/cfg_addr/cfg_data write delay[k] (addr 2k) and width[k] (addr 2k+1), IDLE only;
//   pulse_count_i/trig_edge_i are latched by arm_i; disarm_i aborts; trigger_i is asynchronous;
//   pulse_o is the glitch output, busy_o = DELAY|PULSE, armed_o = ARMED, done_o = completion strobe.
// Optional: define GLITCH_SEQ_AUTO_REARM_EN to add auto_rearm_i (re-arm on completion).
module glitch_pulse_seq #(
  parameter int CNT_W      = 24,
  parameter int NUM_PULSES = 4,
  parameter int TRIG_SYNC  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_we,
  input  logic [$clog2(2*NUM_PULSES)-1:0]   cfg_addr,
  input  logic [CNT_W-1:0]                  cfg_data,
  input  logic [$clog2(NUM_PULSES+1)-1:0]   pulse_count_i,
  input  logic                              trig_edge_i,
  input  logic                              arm_i,
  input  logic                              disarm_i,
  input  logic                              trigger_i,
`ifdef GLITCH_SEQ_AUTO_REARM_EN
  input  logic                              auto_rearm_i,
`endif
  output logic                              pulse_o,
  output logic                              busy_o,
  output logic                              armed_o,
  output logic                              done_o
);
  localparam int AW = $clog2(2*NUM_PULSES);
  localparam int PW = $clog2(NUM_PULSES+1);
  localparam int KW = NUM_PULSES > 1 ? $clog2(NUM_PULSES) : 1;
  typedef enum logic [1:0] {IDLE, ARMED, DELAY, PULSE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] dly_q [NUM_PULSES];
  logic [CNT_W-1:0] dly_d [NUM_PULSES];
  logic [CNT_W-1:0] wid_q [NUM_PULSES];
  logic [CNT_W-1:0] wid_d [NUM_PULSES];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d, last_q, last_d, nk;
  logic [TRIG_SYNC-1:0] sync_q, sync_d;
  logic prev_q, prev_d, pol_q, pol_d, pulse_q, pulse_d, done_q, done_d;
  logic trig_lvl, edge_hit, fin, cfg_ok;
  logic [PW-1:0] pc;
`ifdef GLITCH_SEQ_AUTO_REARM_EN
  localparam int BW = $clog2(TRIG_SYNC+1);
  logic [BW-1:0] blk_q, blk_d;
  // blk_q masks edges for TRIG_SYNC cycles after a re-arm so in-flight trigger history is dropped
  assign edge_hit = state_q == ARMED && blk_q == '0 && (pol_q ? trig_lvl && !prev_q : !trig_lvl && prev_q);
`else
  assign edge_hit = state_q == ARMED && (pol_q ? trig_lvl && !prev_q : !trig_lvl && prev_q);
`endif
  assign sync_d   = {sync_q[TRIG_SYNC-2:0], trigger_i};
  assign trig_lvl = sync_q[TRIG_SYNC-1];
  assign prev_d   = trig_lvl;
  assign nk       = k_q == KW'(NUM_PULSES-1) ? '0 : k_q + 1'b1;
  assign pc       = pulse_count_i == '0 ? PW'(1) :
                    pulse_count_i > PW'(NUM_PULSES) ? PW'(NUM_PULSES) : pulse_count_i;
  assign cfg_ok   = cfg_we && state_q == IDLE;
  assign pulse_o  = pulse_q;
  assign done_o   = done_q;
  assign busy_o   = state_q == DELAY || state_q == PULSE;
  assign armed_o  = state_q == ARMED;
  always_comb begin
    for (int i = 0; i < NUM_PULSES; i++) begin
      dly_d[i] = cfg_ok && cfg_addr == AW'(2*i) ? cfg_data : dly_q[i];
      wid_d[i] = cfg_ok && cfg_addr == AW'(2*i+1) ? cfg_data : wid_q[i];
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    last_d  = last_q;
    pol_d   = pol_q;
    done_d  = 1'b0;
    fin     = 1'b0;
`ifdef GLITCH_SEQ_AUTO_REARM_EN
    blk_d   = blk_q == '0 ? '0 : blk_q - 1'b1;
`endif
    case (state_q)
      IDLE: if (arm_i) begin
        state_d = ARMED;
        pol_d   = trig_edge_i;
        last_d  = KW'(pc - 1'b1);
      end
      ARMED: if (edge_hit) begin
        state_d = DELAY;
        k_d     = '0;
        cnt_d   = dly_q[0];
      end
      DELAY: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (wid_q[k_q] != '0) begin
          state_d = PULSE;
          cnt_d   = wid_q[k_q] - 1'b1;
        end else if (k_q == last_q) fin = 1'b1;
        else begin
          k_d   = nk;
          cnt_d = dly_q[nk];
        end
      end
      PULSE: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (k_q == last_q) fin = 1'b1;
        else if (dly_q[nk] == '0 && wid_q[nk] != '0) begin
          // zero delay: next pulse continues the current one with no low gap
          k_d   = nk;
          cnt_d = wid_q[nk] - 1'b1;
        end else begin
          // the falling edge already spent one low cycle, so the gap counts from delay-1
          state_d = DELAY;
          k_d     = nk;
          cnt_d   = dly_q[nk] == '0 ? '0 : dly_q[nk] - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      done_d  = 1'b1;
`ifdef GLITCH_SEQ_AUTO_REARM_EN
      state_d = auto_rearm_i ? ARMED : IDLE;
      blk_d   = auto_rearm_i ? BW'(TRIG_SYNC) : blk_d;
`else
      state_d = IDLE;
`endif
    end
    if (disarm_i && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
    pulse_d = state_d == PULSE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dly_q   <= '{default: '0};
      wid_q   <= '{default: '0};
      cnt_q   <= '0;
      k_q     <= '0;
      last_q  <= '0;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pol_q   <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef GLITCH_SEQ_AUTO_REARM_EN
      blk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      wid_q   <= wid_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      last_q  <= last_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pol_q   <= pol_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
`ifdef GLITCH_SEQ_AUTO_REARM_EN
      blk_q   <= blk_d;
`endif
    end
  end
endmodule

// File: tb/tb_glitch_pulse_seq.sv
// tb_glitch_pulse_seq: directed table-driven bench for glitch_pulse_seq (default parameters)
module tb_glitch_pulse_seq;
  logic clk = 1'b0;
  logic rst, cfg_we, trig_edge_i, arm_i, disarm_i, trigger_i;
  logic [2:0] cfg_addr, pulse_count_i;
  logic [23:0] cfg_data;
  logic pulse_o, busy_o, armed_o, done_o;
  int errs = 0;
  int checks = 0;
  glitch_pulse_seq dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .pulse_count_i(pulse_count_i), .trig_edge_i(trig_edge_i), .arm_i(arm_i),
    .disarm_i(disarm_i), .trigger_i(trigger_i), .pulse_o(pulse_o), .busy_o(busy_o),
    .armed_o(armed_o), .done_o(done_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  cnt;
    logic        pol;
    int          dly[4];
    int          wid[4];
    int          dis_at;
    logic [63:0] ep;
    logic [63:0] ed;
  } vec_t;
  vec_t tv[5];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input int a, input int d);
    cfg_we = 1'b1;
    cfg_addr = 3'(a);
    cfg_data = 24'(d);
    tick();
    cfg_we = 1'b0;
  endtask
  task automatic arm(input logic [2:0] cnt, input logic pol);
    pulse_count_i = cnt;
    trig_edge_i = pol;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    tick();
  endtask
  task automatic setup(input logic [2:0] cnt, input logic pol, input int dly[4], input int wid[4]);
    for (int k = 0; k < 4; k++) begin
      cfg(2*k, dly[k]);
      cfg(2*k+1, wid[k]);
    end
    trigger_i = ~pol;
    repeat (5) tick();
    arm(cnt, pol);
  endtask
  // trigger is driven just after an edge, so bit i holds the outputs after edge n+i
  task automatic run(input logic pol, input int dis_at, output logic [63:0] p, output logic [63:0] d);
    p = '0;
    d = '0;
    trigger_i = pol;
    for (int i = 0; i < 64; i++) begin
      tick();
      p[i] = pulse_o;
      d[i] = done_o;
      disarm_i = (i == dis_at);
    end
    disarm_i = 1'b0;
  endtask
  initial begin
    logic [63:0] p, d;
    logic seen;
    int dl[4], wd[4];
    tv[0] = '{3'd1, 1'b1, '{10, 0, 0, 0}, '{5, 0, 0, 0}, -1, 64'h3E000, 64'h40000};
    tv[1] = '{3'd3, 1'b1, '{4, 3, 0, 0}, '{2, 6, 1, 0}, -1, 64'h7F180, 64'h80000};
    tv[2] = '{3'd7, 1'b1, '{2, 2, 2, 2}, '{1, 0, 1, 1}, -1, 64'h4820, 64'h8000};
    tv[3] = '{3'd0, 1'b0, '{0, 0, 0, 0}, '{3, 0, 0, 0}, -1, 64'h38, 64'h40};
    tv[4] = '{3'd3, 1'b1, '{2, 2, 2, 0}, '{3, 3, 3, 0}, 11, 64'hCE0, 64'h0};
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    pulse_count_i = '0;
    trig_edge_i = 1'b1;
    arm_i = 1'b0;
    disarm_i = 1'b0;
    trigger_i = 1'b0;
    repeat (3) tick();
    chk("reset outputs", 64'({pulse_o, busy_o, armed_o, done_o}), 64'h0);
    rst = 1'b0;
    tick();
    for (int r = 0; r < 5; r++) begin
      setup(tv[r].cnt, tv[r].pol, tv[r].dly, tv[r].wid);
      chk($sformatf("row%0d armed", r), 64'(armed_o), 64'h1);
      run(tv[r].pol, tv[r].dis_at, p, d);
      chk($sformatf("row%0d pulse", r), p, tv[r].ep);
      chk($sformatf("row%0d done", r), d, tv[r].ed);
      chk($sformatf("row%0d idle", r), 64'({busy_o, armed_o}), 64'h0);
    end
    // arm in the cycle the trigger edge is visible: the edge must not start a sequence
    cfg(0, 0);
    cfg(1, 1);
    trigger_i = 1'b0;
    repeat (5) tick();
    trigger_i = 1'b1;
    tick();
    tick();
    pulse_count_i = 3'd1;
    trig_edge_i = 1'b1;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= pulse_o | busy_o;
    end
    chk("arm same edge no seq", 64'(seen), 64'h0);
    chk("arm same edge armed", 64'(armed_o), 64'h1);
    disarm_i = 1'b1;
    tick();
    disarm_i = 1'b0;
    chk("disarm armed", 64'(armed_o), 64'h0);
    // falling-edge mode ignores a rising edge, then fires on the falling one
    trigger_i = 1'b0;
    repeat (5) tick();
    arm(3'd1, 1'b0);
    trigger_i = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= pulse_o | busy_o;
    end
    chk("falling ignores rise", 64'(seen), 64'h0);
    trigger_i = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen |= pulse_o;
    end
    chk("falling fires", 64'(seen), 64'h1);
    // config writes while armed are dropped
    dl = '{10, 0, 0, 0};
    wd = '{2, 0, 0, 0};
    setup(3'd1, 1'b1, dl, wd);
    cfg(0, 99);
    run(1'b1, -1, p, d);
    chk("lockout pulse", p, 64'h6000);
    chk("lockout done", d, 64'h8000);
    // reset in the middle of a pulse clears outputs and configuration
    dl = '{0, 0, 0, 0};
    wd = '{10, 0, 0, 0};
    setup(3'd1, 1'b1, dl, wd);
    trigger_i = 1'b1;
    repeat (5) tick();
    chk("mid pulse high", 64'(pulse_o), 64'h1);
    rst = 1'b1;
    tick();
    chk("reset mid pulse", 64'({pulse_o, busy_o, armed_o, done_o}), 64'h0);
    rst = 1'b0;
    trigger_i = 1'b0;
    repeat (5) tick();
    arm(3'd1, 1'b1);
    run(1'b1, -1, p, d);
    chk("cleared cfg pulse", p, 64'h0);
    chk("cleared cfg done", d, 64'h8);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
